// File: rtl/count_seq_monitor.sv
// ============================================================================
// Module   : count_seq_monitor
// Purpose  : Receive-side checker for a free-running up-counter. Samples the
//            counter on qualified cycles, locks onto the +1 sequence after
//            LOCK_CNT consecutive correct increments, and then flags every
//            deviation. Saturating error and wrap statistics are kept.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH     bit width of the sampled count (sequence is modulo 2^WIDTH)
//   CNT_W     width of the error / wrap statistics counters
//   LOCK_CNT  consecutive correct increments required to lock (1..15)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   sample qualifier
//   count_in   in   counter value under check [WIDTH]
//   clear      in   synchronous soft clear (back to IDLE, statistics zeroed)
//   locked     out  high while in LOCKED
//   err_pulse  out  one-cycle pulse per mismatch detected while locked
//   err_count  out  saturating mismatch count [CNT_W]
//   wrap_count out  saturating count of correct all-ones->0 wraps [CNT_W]
//   expected   out  prediction for the next sample [WIDTH]
//
// Optional feature (macro COUNT_SEQ_MONITOR_FIRST_ERR_EN)
//   first_err_valid / first_err_exp / first_err_obs capture the predicted and
//   observed values of the first locked mismatch; frozen until rst or clear.
// ============================================================================
`default_nettype none

module count_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_obs
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
  localparam logic [WIDTH-1:0] W_ONE       = WIDTH'(1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;

  logic             sample;
  logic             match;
  logic [3:0]       run_inc;
  logic             lock_err;
  logic             lock_wrap;

  // prev+1 equals the registered expected value whenever a match decision
  // matters (both are written together on every sample), so the comparison
  // is taken from prev directly.
  assign sample    = en & ~clear;
  assign match     = (count_in == (prev + W_ONE));
  assign run_inc   = run + 4'd1;
  assign lock_err  = sample && (state == S_LOCKED) && !match;
  assign lock_wrap = sample && (state == S_LOCKED) && match && (count_in == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else if (sample) begin
      case (state)
        S_IDLE:   state_next = S_SYNC;
        S_SYNC:   if (match && (run_inc == LOCK_TARGET)) state_next = S_LOCKED;
        S_LOCKED: if (!match) state_next = S_SYNC;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Output logic (decoded from the state register only)
  always_comb begin
    locked = (state == S_LOCKED);
  end

  // Datapath: sample history, run length and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= '0;
      expected   <= '0;
      run        <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else if (clear) begin
      prev       <= '0;
      expected   <= '0;
      run        <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_pulse <= lock_err;
      if (sample) begin
        prev     <= count_in;
        expected <= count_in + W_ONE;
        case (state)
          S_IDLE:   run <= '0;
          S_SYNC:   run <= match ? run_inc : 4'd0;
          S_LOCKED: if (!match) run <= '0;
          default:  run <= '0;
        endcase
      end
      if (lock_err && (err_count != '1))
        err_count <= err_count + C_ONE;
      if (lock_wrap && (wrap_count != '1))
        wrap_count <= wrap_count + C_ONE;
    end
  end

`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
  // First locked mismatch capture; frozen once valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_obs   <= '0;
    end else if (clear) begin
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_obs   <= '0;
    end else if (lock_err && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_exp   <= prev + W_ONE;
      first_err_obs   <= count_in;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_seq_monitor.sv
`default_nettype none

module tb_count_seq_monitor;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] count_in = '0;

  logic             locked, err_pulse;
  logic [7:0]       err_count, wrap_count;
  logic [WIDTH-1:0] expected;
  logic             s_locked, s_err_pulse;
  logic [1:0]       s_err_count, s_wrap_count;
  logic [WIDTH-1:0] s_expected;
`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
  logic             fe_valid, s_fe_valid;
  logic [WIDTH-1:0] fe_exp, fe_obs, s_fe_exp, s_fe_obs;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(WIDTH), .CNT_W(8), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .expected(expected)
`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
    , .first_err_valid(fe_valid), .first_err_exp(fe_exp), .first_err_obs(fe_obs)
`endif
  );

  // Narrow-statistics copy for saturation checks, fed the same stimulus.
  count_seq_monitor #(.WIDTH(WIDTH), .CNT_W(2), .LOCK_CNT(LOCK_CNT)) dut_s (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .wrap_count(s_wrap_count), .expected(s_expected)
`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
    , .first_err_valid(s_fe_valid), .first_err_exp(s_fe_exp), .first_err_obs(s_fe_obs)
`endif
  );

  // ---------------- reference model ----------------
  bit         m_idle;
  bit         m_locked;
  bit         m_pulse;
  int         m_run, m_err, m_wrap;
  logic [3:0] m_exp;
  bit         m_fe_valid;
  logic [3:0] m_fe_exp, m_fe_obs;

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_locked = 0; m_pulse = 0; m_run = 0; m_err = 0; m_wrap = 0;
    m_exp = '0; m_fe_valid = 0; m_fe_exp = '0; m_fe_obs = '0;
  endtask

  task automatic model_step(input bit e, input bit c, input logic [3:0] v);
    bit hit;
    hit = (v == m_exp);
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else if (e) begin
      if (m_idle) begin
        m_idle = 0; m_run = 0;
      end else if (!m_locked) begin
        if (hit) begin
          m_run++;
          if (m_run == LOCK_CNT) m_locked = 1;
        end else m_run = 0;
      end else if (!hit) begin
        m_pulse = 1; m_err++; m_locked = 0; m_run = 0;
        if (!m_fe_valid) begin m_fe_valid = 1; m_fe_exp = m_exp; m_fe_obs = v; end
      end else if (v == 4'd0) begin
        m_wrap++;
      end
      m_exp = v + 4'd1;
    end
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // return 1 time unit after the rising edge for sampling.
  task automatic apply(input bit e, input bit c, input logic [3:0] v);
    @(negedge clk);
    en = e; clear = c; count_in = v;
    @(posedge clk);
    model_step(e, c, v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; en = 0; clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = ~en; count_in = 4'(i + 3);
      #2;
      total++;
      if ({locked, err_pulse, err_count, wrap_count, expected} !== '0) begin
        bad++;
        $display("FAIL reset_hold: locked=%b pulse=%b err=%0d wrap=%0d exp=%0d, want all 0",
                 locked, err_pulse, err_count, wrap_count, expected);
      end
    end
    @(negedge clk);
    en = 0; rst = 1;
    repeat (2) apply(0, 0, 4'd9);
    total++;
    if ({locked, err_pulse, err_count, wrap_count, expected} !== '0) begin
      bad++;
      $display("FAIL reset_release: locked=%b pulse=%b err=%0d wrap=%0d exp=%0d, want all 0",
               locked, err_pulse, err_count, wrap_count, expected);
    end
  endtask

  task automatic test_lock();
    do_reset();
    apply(1, 0, 4'd0);
    apply(1, 0, 4'd1);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: locked=%b want 0", locked); end
    apply(1, 0, 4'd2);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_acquire: locked=%b want 1", locked); end
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL lock_err: err_count=%0d want 0", err_count); end
    total++;
    if (expected !== 4'd3) begin bad++; $display("FAIL lock_expected: expected=%0d want 3", expected); end
  endtask

  task automatic test_wrap();
    for (int v = 3; v <= 16; v++) apply(1, 0, 4'(v));
    total++;
    if (wrap_count !== 8'd1) begin bad++; $display("FAIL wrap_count: got %0d want 1", wrap_count); end
    total++;
    if (err_count !== 8'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL wrap_state: err=%0d locked=%b want 0/1", err_count, locked);
    end
  endtask

  task automatic test_error_relock();
    do_reset();
    for (int v = 3; v <= 5; v++) apply(1, 0, 4'(v));
    apply(1, 0, 4'd9);
    total++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL err_detect: pulse=%b err=%0d locked=%b want 1/1/0", err_pulse, err_count, locked);
    end
`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
    total++;
    if (fe_valid !== 1'b1 || fe_exp !== 4'd6 || fe_obs !== 4'd9) begin
      bad++; $display("FAIL first_err: v=%b exp=%0d obs=%0d want 1/6/9", fe_valid, fe_exp, fe_obs);
    end
`endif
    apply(0, 0, 4'd2);
    total++;
    if (err_pulse !== 1'b0) begin bad++; $display("FAIL err_pulse_width: pulse=%b want 0", err_pulse); end
    apply(1, 0, 4'd10);
    apply(1, 0, 4'd11);
    total++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      bad++; $display("FAIL relock: locked=%b err=%0d want 1/1", locked, err_count);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int v = 1; v <= 3; v++) apply(1, 0, 4'(v));
    repeat (4) apply(0, 0, 4'd7);
    total++;
    if (expected !== 4'd4 || locked !== 1'b1) begin
      bad++; $display("FAIL gap_hold: expected=%0d locked=%b want 4/1", expected, locked);
    end
    apply(1, 0, 4'd4);
    total++;
    if (err_pulse !== 1'b0 || err_count !== 8'd0 || expected !== 4'd5) begin
      bad++; $display("FAIL gap_resume: pulse=%b err=%0d exp=%0d want 0/0/5", err_pulse, err_count, expected);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] b;
    do_reset();
    for (int v = 0; v <= 2; v++) apply(1, 0, 4'(v));
    for (int k = 0; k < 5; k++) begin
      b = m_exp + 4'd5;
      apply(1, 0, b);
      apply(1, 0, b + 4'd1);
      apply(1, 0, b + 4'd2);
    end
    total++;
    if (s_err_count !== 2'd3) begin bad++; $display("FAIL sat_narrow: err_count=%0d want 3", s_err_count); end
    total++;
    if (err_count !== 8'd5) begin bad++; $display("FAIL sat_wide: err_count=%0d want 5", err_count); end
    apply(1, 1, m_exp);
    total++;
    if (s_err_count !== 2'd0 || s_locked !== 1'b0 || s_expected !== 4'd0 || err_count !== 8'd0) begin
      bad++; $display("FAIL clear: err=%0d locked=%b exp=%0d wide_err=%0d want 0/0/0/0",
                      s_err_count, s_locked, s_expected, err_count);
    end
    apply(0, 0, 4'd0);
    total++;
    if (expected !== 4'd0 || locked !== 1'b0) begin
      bad++; $display("FAIL clear_discard: expected=%0d locked=%b want 0/0", expected, locked);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int v = 0; v <= 2; v++) apply(1, 0, 4'(v));
    #2;
    rst = 0;
    model_reset();
    #1;
    total++;
    if (locked !== 1'b0 || expected !== 4'd0) begin
      bad++; $display("FAIL async_reset: locked=%b exp=%0d want 0/0", locked, expected);
    end
    @(negedge clk);
    rst = 1;
    apply(1, 0, 4'd5);
    total++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || expected !== 4'd6) begin
      bad++; $display("FAIL post_reset_sample: locked=%b pulse=%b exp=%0d want 0/0/6", locked, err_pulse, expected);
    end
  endtask

  task automatic test_random();
    logic [3:0] cnt, v;
    int         r;
    bit         e, c;
    do_reset();
    cnt = 4'($urandom_range(0, 15));
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 2);
      e = (r % 4 != 0);
      v = (r >= 90) ? 4'($urandom_range(0, 15)) : cnt;
      if (e) cnt = v + 4'd1;
      apply(e, c, v);
      total++;
      if (locked !== m_locked || err_pulse !== m_pulse || expected !== m_exp) begin
        bad++; $display("FAIL rand_ctl[%0d]: locked=%b pulse=%b exp=%0d want %b/%b/%0d",
                        i, locked, err_pulse, expected, m_locked, m_pulse, m_exp);
      end
      total++;
      if (err_count !== 8'(sat(m_err, 255)) || wrap_count !== 8'(sat(m_wrap, 255))) begin
        bad++; $display("FAIL rand_stats[%0d]: err=%0d wrap=%0d want %0d/%0d",
                        i, err_count, wrap_count, sat(m_err, 255), sat(m_wrap, 255));
      end
      total++;
      if (s_err_count !== 2'(sat(m_err, 3)) || s_wrap_count !== 2'(sat(m_wrap, 3))) begin
        bad++; $display("FAIL rand_sat[%0d]: err=%0d wrap=%0d want %0d/%0d",
                        i, s_err_count, s_wrap_count, sat(m_err, 3), sat(m_wrap, 3));
      end
`ifdef COUNT_SEQ_MONITOR_FIRST_ERR_EN
      total++;
      if (fe_valid !== m_fe_valid || fe_exp !== m_fe_exp || fe_obs !== m_fe_obs) begin
        bad++; $display("FAIL rand_first_err[%0d]: %b/%0d/%0d want %b/%0d/%0d",
                        i, fe_valid, fe_exp, fe_obs, m_fe_valid, m_fe_exp, m_fe_obs);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_error_relock();
    test_gaps();
    test_saturation();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Receive-side checker for the free-running up-counter output (`count`) in the counter testbench environment.
- Samples the counter value on qualified cycles, locks onto the increment sequence, then flags every deviation.
- Counts errors and wrap-arounds so a top-level bench can report counter health without a behavioural model.

Parameters:
- WIDTH, 4, bit width of the sampled count; the sequence is modulo 2^WIDTH.
- CNT_W, 8, width of the error and wrap statistics counters.
- LOCK_CNT, 2, consecutive correct increments required to declare lock; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; count_in is evaluated only when en=1.
- count_in  input  WIDTH  counter value under check.
- clear  input  1  synchronous soft clear: returns to IDLE and zeroes statistics.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- err_count  output  CNT_W  mismatches since reset or clear; saturates at all-ones.
- wrap_count  output  CNT_W  correct wraps (all-ones to 0) seen while locked; saturates.
- expected  output  WIDTH  prediction for the next sample, equal to prev+1 mod 2^WIDTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - prev, run, locked, err_pulse, err_count, wrap_count and expected all reset to 0.
- Internal registers:
  - prev (WIDTH): last accepted sample.
  - run (4 bits): consecutive correct increments seen in SYNC.
- Sample cycles: only cycles with en=1 and clear=0 are sample cycles. Every sample cycle updates prev<=count_in and expected<=count_in+1 (mod 2^WIDTH).
- Non-sample cycles: cycles with en=0 change nothing except err_pulse, which returns to 0.
- IDLE:
  - On a sample: go to SYNC with run=0.
  - No error is possible in IDLE.
- SYNC:
  - On a sample with count_in==expected: run<=run+1. If run+1==LOCK_CNT, go to LOCKED.
  - On a sample with count_in!=expected: run<=0 and stay in SYNC. No error is flagged; the FSM is still acquiring.
- LOCKED:
  - On a sample with count_in==expected: stay in LOCKED. If count_in==0, wrap_count increments (saturating).
  - On a sample with count_in!=expected: err_pulse<=1 for exactly one cycle, err_count increments (saturating), go to SYNC with run=0. The mismatching sample becomes prev.
  - A repeated value (e.g. the counter held in reset, output stuck at 0) is a mismatch.
- Latency:
  - All outputs are registered.
  - err_pulse, locked, err_count and wrap_count reflect a sample on the cycle after the clock edge that accepted it.
- clear=1 (synchronous, highest priority after rst):
  - State goes to IDLE; run, err_count, wrap_count and err_pulse go to 0.
  - prev and expected are also cleared to 0.
  - A simultaneous en sample is discarded.
- Saturation: err_count and wrap_count hold at 2^CNT_W-1 and never wrap.
- Reset mid-operation: rst overrides everything immediately; the first sample after release behaves exactly as from IDLE.

Optional Feature:
- Macro: COUNT_SEQ_MONITOR_FIRST_ERR_EN.
- When defined, three extra outputs are added:
  - first_err_valid (1)
  - first_err_exp (WIDTH)
  - first_err_obs (WIDTH)
- On the first LOCKED mismatch after reset or clear, the feature captures expected and count_in and sets first_err_valid=1. These values then stay frozen until rst or clear, which zero all three.
- When not defined, the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 with en toggling -> locked=0, err_pulse=0, err_count=0, wrap_count=0, expected=0; release rst -> values unchanged until the first sample.
- Lock acquisition, LOCK_CNT=2: samples 0,1,2 on consecutive en cycles -> locked=1 the cycle after sample 2; err_count=0; expected=3.
- Wrap counting: after lock, drive 3..15 then 0 -> wrap_count=1, err_count=0, locked stays 1.
- Error and relock:
  - Locked with prev=5, drive 9 -> err_pulse high exactly one cycle, err_count=1, locked=0.
  - Then drive 10,11 -> locked=1 again.
  - With FIRST_ERR_EN: first_err_exp=6, first_err_obs=9.
- Qualifier gaps: locked at prev=3, en=0 for 4 cycles with count_in=7, then en=1 with count_in=4 -> no error, expected=5.
- Clear and saturation:
  - CNT_W=2: force 5 mismatches -> err_count saturates at 3.
  - Then clear=1 together with en=1 -> IDLE, err_count=0, locked=0, sample ignored.
